// File: rtl/tspp_fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
interface tspp_fetch_stage_if;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        imem_busy;
  logic [31:0] imem_rdata;
  logic        imem_error;

  // Fetch stage issues the request and consumes the response.
  modport master (
    output imem_ren, imem_addr,
    input  imem_busy, imem_rdata, imem_error
  );

  // Memory side answers the request.
  modport slave (
    input  imem_ren, imem_addr,
    output imem_busy, imem_rdata, imem_error
  );
endinterface

// File: rtl/tspp_fetch_stage.sv
// Fetch stage: owns the PC, drives one outstanding imem read, drops the data of
// a read that was overtaken by a redirect, and fills the fetch/execute latch.
module tspp_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                      CLK,
  input  logic                      nRST,
  // hazard unit controls
  input  logic                      pc_en,
  input  logic                      npc_sel,
  input  logic                      if_ex_stall,
  input  logic                      if_ex_flush,
  input  logic [31:0]               priv_pc,
  input  logic                      insert_priv_pc,
  input  logic [31:0]               brj_addr,
  input  logic                      pred_taken,
  input  logic [31:0]               pred_target,
  // imem bus
  tspp_fetch_stage_if.master        imem,
  // status to hazard unit
  output logic                      iren,
  output logic                      i_mem_busy,
  output logic                      fault_insn,
  output logic                      mal_insn,
  output logic [31:0]               epc_f,
  output logic [31:0]               badaddr_f,
  // fetch/execute latch
  output logic                      fe_valid,
  output logic [31:0]               fe_instr,
  output logic [31:0]               fe_pc,
  output logic [31:0]               fe_pc4,
  output logic                      fe_prediction
);

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        fe_valid_q, fe_valid_d;
  logic [31:0] fe_instr_q, fe_instr_d;
  logic [31:0] fe_pc_q, fe_pc_d;
  logic [31:0] fe_pc4_q, fe_pc4_d;
  logic        fe_pred_q, fe_pred_d;

  logic        ren;
  logic        fetch_ok;
  logic        fetch_fault;
  logic        busy_status;

  // Redirect request and its target; a trap vector always beats a branch.
  logic        redir_req;
  logic [31:0] redir_tgt;
  logic [31:0] pc_plus4;
  logic        misaligned;

  assign redir_req  = insert_priv_pc | npc_sel;
  assign redir_tgt  = insert_priv_pc ? priv_pc : brj_addr;
  assign pc_plus4   = pc_q + 32'd4;
  assign misaligned = (pc_q[1:0] != 2'b00);

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // FSM next state: a redirect during an outstanding read parks us in DISCARD
  // until that read retires, so the stale word never reaches the latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (ren && imem.imem_busy && redir_req) state_d = S_DISCARD;
      S_DISCARD: if (!imem.imem_busy)                    state_d = S_FETCH;
      default:                                           state_d = S_FETCH;
    endcase
  end

  // FSM outputs: request enable, busy status, completion qualifiers.
  always_comb begin
    ren         = (state_q == S_FETCH) && !misaligned;
    busy_status = (ren && imem.imem_busy) || (state_q == S_DISCARD);
    fetch_fault = ren && !imem.imem_busy &&  imem.imem_error;
    fetch_ok    = ren && !imem.imem_busy && !imem.imem_error;
  end

  // PC and pending-redirect next state.
  always_comb begin
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    if (state_q == S_DISCARD) begin
      // Latest redirect wins; it is applied once the dropped read retires.
      if (redir_req)         redirect_pc_d = redir_tgt;
      if (!imem.imem_busy)   pc_d          = redirect_pc_d;
    end else if (state_d == S_DISCARD) begin
      // Hold pc so imem_addr stays stable for the read being abandoned.
      redirect_pc_d = redir_tgt;
    end else if (pc_en) begin
      if (insert_priv_pc)    pc_d = priv_pc;
      else if (npc_sel)      pc_d = brj_addr;
      else if (pred_taken)   pc_d = pred_target;
      else                   pc_d = pc_plus4;
    end
  end

  // PC and pending-redirect registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q          <= RESET_PC;
      redirect_pc_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Latch next state: flush beats stall, stall holds everything.
  always_comb begin
    fe_valid_d = fe_valid_q;
    fe_instr_d = fe_instr_q;
    fe_pc_d    = fe_pc_q;
    fe_pc4_d   = fe_pc4_q;
    fe_pred_d  = fe_pred_q;
    if (if_ex_flush) begin
      fe_valid_d = 1'b0;
      fe_instr_d = NOP_INSN;
    end else if (!if_ex_stall) begin
      fe_valid_d = fetch_ok;
      fe_instr_d = fetch_ok ? imem.imem_rdata : NOP_INSN;
      fe_pc_d    = pc_q;
      fe_pc4_d   = pc_plus4;
      fe_pred_d  = pred_taken;
    end
  end

  // Fetch/execute latch registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fe_valid_q <= 1'b0;
      fe_instr_q <= NOP_INSN;
      fe_pc_q    <= 32'h0;
      fe_pc4_q   <= 32'h0;
      fe_pred_q  <= 1'b0;
    end else begin
      fe_valid_q <= fe_valid_d;
      fe_instr_q <= fe_instr_d;
      fe_pc_q    <= fe_pc_d;
      fe_pc4_q   <= fe_pc4_d;
      fe_pred_q  <= fe_pred_d;
    end
  end

  assign imem.imem_ren  = ren;
  assign imem.imem_addr = pc_q;
  assign iren           = ren;
  assign i_mem_busy     = busy_status;
  assign fault_insn     = fetch_fault;
  assign mal_insn       = misaligned;
  assign epc_f          = pc_q;
  assign badaddr_f      = pc_q;
  assign fe_valid       = fe_valid_q;
  assign fe_instr       = fe_instr_q;
  assign fe_pc          = fe_pc_q;
  assign fe_pc4         = fe_pc4_q;
  assign fe_prediction  = fe_pred_q;

endmodule

// File: tb/tb_tspp_fetch_stage.sv
// Bench for the fetch stage: directed scenarios plus random traffic, all
// checked against a transaction-level model of the fetch rules.
module tb_tspp_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0200;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, npc_sel, if_ex_stall, if_ex_flush, insert_priv_pc, pred_taken;
  logic [31:0] priv_pc, brj_addr, pred_target;
  logic        iren, i_mem_busy, fault_insn, mal_insn;
  logic [31:0] epc_f, badaddr_f;
  logic        fe_valid, fe_prediction;
  logic [31:0] fe_instr, fe_pc, fe_pc4;

  tspp_fetch_stage_if imem_bus ();

  tspp_fetch_stage dut (
    .CLK(CLK), .nRST(nRST),
    .pc_en(pc_en), .npc_sel(npc_sel), .if_ex_stall(if_ex_stall), .if_ex_flush(if_ex_flush),
    .priv_pc(priv_pc), .insert_priv_pc(insert_priv_pc), .brj_addr(brj_addr),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .imem(imem_bus.master),
    .iren(iren), .i_mem_busy(i_mem_busy), .fault_insn(fault_insn), .mal_insn(mal_insn),
    .epc_f(epc_f), .badaddr_f(badaddr_f),
    .fe_valid(fe_valid), .fe_instr(fe_instr), .fe_pc(fe_pc), .fe_pc4(fe_pc4),
    .fe_prediction(fe_prediction)
  );

  always #5 CLK = ~CLK;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Model: where the PC is, whether the read in flight is to be dropped and
  // where to go afterwards, and what the latch currently shows.
  logic [31:0] m_pc, m_after;
  bit          m_dropping;
  bit          m_fv, m_fp;
  logic [31:0] m_fi, m_fpc, m_fpc4;

  task automatic model_reset();
    m_pc = RST_PC; m_after = 32'h0; m_dropping = 0;
    m_fv = 0; m_fp = 0; m_fi = NOP; m_fpc = 32'h0; m_fpc4 = 32'h0;
  endtask

  // One clock: check visible outputs against the model, advance the model, clock.
  task automatic tick();
    bit          busy, err, aligned, req, done, redir;
    logic [31:0] tgt;
    #1;
    busy    = imem_bus.imem_busy;
    err     = imem_bus.imem_error;
    aligned = (m_pc % 4) == 0;
    req     = !m_dropping && aligned;
    done    = req && !busy;
    redir   = insert_priv_pc || npc_sel;
    tgt     = insert_priv_pc ? priv_pc : brj_addr;

    chk("imem_ren",   {31'b0, imem_bus.imem_ren}, {31'b0, req});
    chk("iren",       {31'b0, iren},              {31'b0, req});
    chk("imem_addr",  imem_bus.imem_addr,         m_pc);
    chk("i_mem_busy", {31'b0, i_mem_busy},        {31'b0, (req && busy) || m_dropping});
    chk("fault_insn", {31'b0, fault_insn},        {31'b0, done && err});
    chk("mal_insn",   {31'b0, mal_insn},          {31'b0, !aligned});
    chk("epc_f",      epc_f,                      m_pc);
    chk("badaddr_f",  badaddr_f,                  m_pc);
    chk("fe_valid",   {31'b0, fe_valid},          {31'b0, m_fv});
    chk("fe_instr",   fe_instr,                   m_fi);
    chk("fe_pc",      fe_pc,                      m_fpc);
    chk("fe_pc4",     fe_pc4,                     m_fpc4);
    chk("fe_pred",    {31'b0, fe_prediction},     {31'b0, m_fp});

    if (if_ex_flush) begin
      m_fv = 0; m_fi = NOP;
    end else if (!if_ex_stall) begin
      m_fv   = done && !err;
      m_fi   = m_fv ? imem_bus.imem_rdata : NOP;
      m_fpc  = m_pc;
      m_fpc4 = m_pc + 32'd4;
      m_fp   = pred_taken;
    end

    if (m_dropping) begin
      if (redir) m_after = tgt;
      if (!busy) begin m_pc = m_after; m_dropping = 0; end
    end else if (req && busy && redir) begin
      m_dropping = 1; m_after = tgt;
    end else if (pc_en) begin
      if (insert_priv_pc)  m_pc = priv_pc;
      else if (npc_sel)    m_pc = brj_addr;
      else if (pred_taken) m_pc = pred_target;
      else                 m_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    pc_en = 0; npc_sel = 0; if_ex_stall = 0; if_ex_flush = 0; insert_priv_pc = 0;
    pred_taken = 0; priv_pc = 0; brj_addr = 0; pred_target = 0;
    imem_bus.imem_busy = 0; imem_bus.imem_rdata = 32'h0010_0093; imem_bus.imem_error = 0;
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] r;
    int sel;
    r = $urandom();
    sel = $urandom_range(0, 15);
    if (sel == 0)      return 32'hFFFF_FFFC;
    else if (sel == 1) return r | 32'h2;
    else               return r & 32'hFFFF_FFFC;
  endfunction

  initial begin
    idle_inputs();
    nRST = 0;
    model_reset();
    @(negedge CLK);
    chk("rst_addr",   imem_bus.imem_addr, RST_PC);
    chk("rst_valid",  {31'b0, fe_valid}, 32'h0);
    chk("rst_instr",  fe_instr, NOP);
    chk("rst_fe_pc",  fe_pc, 32'h0);
    nRST = 1;

    // zero-wait fetch at 0x200
    pc_en = 1; tick();
    chk("seq_addr204", imem_bus.imem_addr, 32'h204);
    chk("seq_instr",   fe_instr, 32'h0010_0093);
    chk("seq_fe_pc",   fe_pc, 32'h200);
    chk("seq_fe_pc4",  fe_pc4, 32'h204);

    // three wait states at 0x204
    pc_en = 0; imem_bus.imem_busy = 1;
    repeat (3) tick();
    pc_en = 1; imem_bus.imem_busy = 0; imem_bus.imem_rdata = 32'h0020_0113; tick();
    chk("wait_valid", {31'b0, fe_valid}, 32'h1);

    // branch while busy at 0x208
    pc_en = 0; imem_bus.imem_busy = 1; npc_sel = 1; brj_addr = 32'h300; tick();
    npc_sel = 0; tick();
    imem_bus.imem_busy = 0; tick();
    chk("drop_valid", {31'b0, fe_valid}, 32'h0);
    chk("drop_addr",  imem_bus.imem_addr, 32'h300);

    // trap vector and branch together while busy at 0x300
    imem_bus.imem_busy = 1; npc_sel = 1; brj_addr = 32'h500;
    insert_priv_pc = 1; priv_pc = 32'h100; tick();
    npc_sel = 0; insert_priv_pc = 0; imem_bus.imem_busy = 0; tick();
    chk("priv_addr", imem_bus.imem_addr, 32'h100);

    // misaligned pc
    pc_en = 1; npc_sel = 1; brj_addr = 32'h202; tick();
    npc_sel = 0; pc_en = 0;
    #1;
    chk("mal_flag",    {31'b0, mal_insn}, 32'h1);
    chk("mal_ren",     {31'b0, imem_bus.imem_ren}, 32'h0);
    chk("mal_badaddr", badaddr_f, 32'h202);
    chk("mal_epc",     epc_f, 32'h202);
    pc_en = 1; npc_sel = 1; brj_addr = 32'h400; tick();
    npc_sel = 0; imem_bus.imem_error = 1; tick();
    chk("err_valid", {31'b0, fe_valid}, 32'h0);
    imem_bus.imem_error = 0; tick();

    // flush and stall together, then stall alone
    if_ex_stall = 1; if_ex_flush = 1; tick();
    chk("flush_valid", {31'b0, fe_valid}, 32'h0);
    chk("flush_instr", fe_instr, NOP);
    if_ex_stall = 0; if_ex_flush = 0; imem_bus.imem_rdata = 32'h0030_0193; tick();
    if_ex_stall = 1; imem_bus.imem_rdata = 32'hDEAD_BEEF; pred_taken = 1; pred_target = 32'h800;
    repeat (2) tick();
    if_ex_stall = 0; pred_taken = 0;

    // wrap past the top of the address space
    npc_sel = 1; brj_addr = 32'hFFFF_FFFC; tick();
    npc_sel = 0; tick();
    chk("wrap_addr", imem_bus.imem_addr, 32'h0);

    // asynchronous reset while dropping a read
    imem_bus.imem_busy = 1; npc_sel = 1; brj_addr = 32'h600; tick();
    npc_sel = 0;
    #2 nRST = 0;
    #1;
    chk("arst_addr",  imem_bus.imem_addr, RST_PC);
    chk("arst_valid", {31'b0, fe_valid}, 32'h0);
    imem_bus.imem_busy = 0;
    #1 chk("arst_state", {31'b0, i_mem_busy}, 32'h0);
    model_reset();
    @(negedge CLK);
    nRST = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      pc_en              = ($urandom_range(0, 9) != 0);
      npc_sel            = ($urandom_range(0, 7) == 0);
      insert_priv_pc     = ($urandom_range(0, 19) == 0);
      pred_taken         = ($urandom_range(0, 4) == 0);
      if_ex_stall        = ($urandom_range(0, 9) == 0);
      if_ex_flush        = ($urandom_range(0, 9) == 0);
      brj_addr           = rand_tgt();
      priv_pc            = rand_tgt();
      pred_target        = rand_tgt();
      imem_bus.imem_busy  = ($urandom_range(0, 3) == 0);
      imem_bus.imem_error = ($urandom_range(0, 15) == 0);
      imem_bus.imem_rdata = $urandom();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
